// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM states, latched command layout, defaults.
// Optional watchdog is enabled with `define VRAM_ARB_TIMEOUT_EN.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W     = 24;
  localparam int VRAM_DATA_W     = 16;
  localparam int VRAM_MASK_W     = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                   wr;
    logic [VRAM_MASK_W-1:0] mask;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_cmd_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1) % n;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Framebuffer access bus between the arbiter (master) and the VRAM port (slave).
interface vram_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);
  logic                   vram_sel_o;
  logic                   vram_wr_o;
  logic [VRAM_MASK_W-1:0] vram_mask_o;
  logic [ADDR_W-1:0]      vram_addr_o;
  logic [DATA_W-1:0]      vram_data_o;
  logic                   vram_ack_i;
  logic [DATA_W-1:0]      vram_data_i;

  modport master (
    output vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o,
    input  vram_ack_i, vram_data_i
  );

  modport slave (
    input  vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o,
    output vram_ack_i, vram_data_i
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the pointer; the first hit wins and later candidates are ignored.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!hit_o && req_i[cand_s]) begin
        hit_o = 1'b1;
        idx_o = cand_s;
      end else begin
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one framebuffer VRAM port between NUM_REQ requesters.
// `define VRAM_ARB_TIMEOUT_EN adds the ISSUE watchdog and the sticky timeout_o output.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int ADDR_W      = VRAM_ADDR_W,
  parameter  int DATA_W      = VRAM_DATA_W,
`ifdef VRAM_ARB_TIMEOUT_EN
  parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n_i,
  input  logic [NUM_REQ-1:0]          req_sel_i,
  input  logic [NUM_REQ-1:0]          req_wr_i,
  input  logic [NUM_REQ*VRAM_MASK_W-1:0] req_mask_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ack_o,
  output logic [DATA_W-1:0]           req_data_o,
  vram_arbiter_if.master              vram,
  output logic [IDX_W-1:0]            grant_o,
`ifdef VRAM_ARB_TIMEOUT_EN
  output logic                        timeout_o,
`endif
  output logic                        busy_o
);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    gnt_q;
  vram_cmd_t           cmd_q;
  logic                sel_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                hit_s;
  logic [IDX_W-1:0]    idx_s;

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0]    cnt_q;
  logic                to_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req_sel_i),
    .ptr_i (rr_ptr_q),
    .hit_o (hit_s),
    .idx_o (idx_s)
  );

  // Transaction FSM; all bus and requester outputs come straight from these registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= {IDX_W{1'b0}};
      gnt_q    <= {IDX_W{1'b0}};
      cmd_q    <= '0;
      sel_q    <= 1'b0;
      ack_q    <= {NUM_REQ{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
`ifdef VRAM_ARB_TIMEOUT_EN
      cnt_q    <= {CNT_W{1'b0}};
      to_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= {NUM_REQ{1'b0}};
          if (hit_s) begin
            gnt_q      <= idx_s;
            cmd_q.wr   <= req_wr_i[idx_s];
            cmd_q.mask <= req_mask_i[int'(idx_s)*VRAM_MASK_W +: VRAM_MASK_W];
            cmd_q.addr <= req_addr_i[int'(idx_s)*ADDR_W +: ADDR_W];
            cmd_q.data <= req_data_i[int'(idx_s)*DATA_W +: DATA_W];
            sel_q      <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
`ifdef VRAM_ARB_TIMEOUT_EN
            cnt_q      <= {CNT_W{1'b0}};
`endif
          end
        end
        ISSUE: begin
          if (vram.vram_ack_i) begin
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
            rdata_q  <= vram.vram_data_i;
            rr_ptr_q <= IDX_W'(wrap_inc(int'(gnt_q), NUM_REQ));
            state_q  <= RELEASE;
          end
`ifdef VRAM_ARB_TIMEOUT_EN
          // Watchdog: abandon the access and report it as a zero-data completion.
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
            rdata_q  <= {DATA_W{1'b0}};
            rr_ptr_q <= IDX_W'(wrap_inc(int'(gnt_q), NUM_REQ));
            to_q     <= 1'b1;
            state_q  <= RELEASE;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RELEASE: begin
          ack_q   <= {NUM_REQ{1'b0}};
          state_q <= IDLE;
        end
        default: begin
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          ack_q   <= {NUM_REQ{1'b0}};
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vram.vram_sel_o  = sel_q;
  assign vram.vram_wr_o   = cmd_q.wr;
  assign vram.vram_mask_o = cmd_q.mask;
  assign vram.vram_addr_o = cmd_q.addr;
  assign vram.vram_data_o = cmd_q.data;
  assign req_ack_o        = ack_q;
  assign req_data_o       = rdata_q;
  assign grant_o          = gnt_q;
  assign busy_o           = busy_q;
`ifdef VRAM_ARB_TIMEOUT_EN
  assign timeout_o        = to_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_vram_arbiter;

  localparam int N  = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n_i = 1'b1;
  logic [N-1:0]    req_sel_i = '0;
  logic [N-1:0]    req_wr_i = '0;
  logic [N*4-1:0]  req_mask_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ack_o;
  logic [DW-1:0]   req_data_o;
  logic [IW-1:0]   grant_o;
  logic            busy_o;
`ifdef VRAM_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) vif();

  vram_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef VRAM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .req_sel_i(req_sel_i), .req_wr_i(req_wr_i), .req_mask_i(req_mask_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .req_data_o(req_data_o),
    .vram(vif),
    .grant_o(grant_o),
`ifdef VRAM_ARB_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int model_ptr = 0;
  logic          c_wr   [N];
  logic [3:0]    c_mask [N];
  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_data [N];

  function automatic int rr_pick(logic [N-1:0] pend, int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [AW+DW+4:0] exp_cmd(int r);
    return {c_wr[r], c_mask[r], c_addr[r], c_data[r]};
  endfunction

  function automatic logic [AW+DW+4:0] bus_cmd();
    return {vif.vram_wr_o, vif.vram_mask_o, vif.vram_addr_o, vif.vram_data_o};
  endfunction

  task automatic set_req(int r, logic wr, logic [3:0] m, logic [AW-1:0] a, logic [DW-1:0] d);
    c_wr[r] = wr; c_mask[r] = m; c_addr[r] = a; c_data[r] = d;
    req_wr_i[r] = wr;
    req_mask_i[r*4 +: 4] = m;
    req_addr_i[r*AW +: AW] = a;
    req_data_i[r*DW +: DW] = d;
    req_sel_i[r] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i = 1'b0;
    req_sel_i = '0;
    vif.vram_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    model_ptr = 0;
  endtask

  task automatic wait_sel(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (vif.vram_sel_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic serve(int lat, logic [DW-1:0] rd);
    repeat (lat) @(negedge clk);
    vif.vram_ack_i = 1'b1;
    vif.vram_data_i = rd;
    @(negedge clk);
    vif.vram_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    #1 reset_n_i = 1'b0;
    vif.vram_ack_i = 1'b0;
    vif.vram_data_i = '0;
    @(negedge clk);
    outs = {vif.vram_sel_o, bus_cmd(), req_ack_o, req_data_o, grant_o, busy_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", outs); end
    @(negedge clk);
    reset_n_i = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    outs = {vif.vram_sel_o, bus_cmd(), req_ack_o, req_data_o, grant_o, busy_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_idle: got %h want 0", outs); end
  endtask

  task automatic test_single_read();
    bit ok; int cyc;
    do_reset();
    set_req(0, 1'b0, 4'h0, 24'h000123, 16'h0000);
    wait_sel(ok, cyc);
    total++;
    if (!ok || cyc != 1) begin bad++; $display("FAIL read_sel_latency: got ok=%0d cyc=%0d want 1 1", ok, cyc); end
    total++;
    if ({vif.vram_addr_o, vif.vram_wr_o, grant_o, busy_o} !== {24'h000123, 1'b0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL read_issue: got addr=%h wr=%b g=%0d busy=%b want 000123 0 0 1",
                      vif.vram_addr_o, vif.vram_wr_o, grant_o, busy_o);
    end
    serve(5, 16'hBEEF);
    total++;
    if ({req_ack_o, req_data_o, vif.vram_sel_o} !== {3'b001, 16'hBEEF, 1'b0}) begin
      bad++; $display("FAIL read_ack: got ack=%b data=%h sel=%b want 001 beef 0", req_ack_o, req_data_o, vif.vram_sel_o);
    end
    req_sel_i[0] = 1'b0;
    model_ptr = 1;
    @(negedge clk);
    total++;
    if (req_ack_o !== 3'b000) begin bad++; $display("FAIL read_ack_width: got %b want 000", req_ack_o); end
  endtask

  task automatic test_simultaneous();
    bit ok; int cyc, e;
    logic [DW-1:0] seq [4];
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h1111; seq[3] = 16'h2222;
    do_reset();
    set_req(0, 1'b1, 4'hF, 24'h000010, 16'h1111);
    set_req(1, 1'b1, 4'hF, 24'h000020, 16'h2222);
    for (int t = 0; t < 4; t++) begin
      e = rr_pick(req_sel_i, model_ptr);
      wait_sel(ok, cyc);
      total++;
      if (!ok || vif.vram_data_o !== seq[t] || int'(grant_o) != e || bus_cmd() !== exp_cmd(e)) begin
        bad++; $display("FAIL simul_grant%0d: got data=%h g=%0d want %h %0d", t, vif.vram_data_o, grant_o, seq[t], e);
      end
      serve(2, 16'h0000);
      total++;
      if (req_ack_o !== oh(e)) begin bad++; $display("FAIL simul_ack%0d: got %b want %b", t, req_ack_o, oh(e)); end
      model_ptr = (e + 1) % N;
      @(negedge clk);
      total++;
      if (req_ack_o !== 3'b000) begin bad++; $display("FAIL simul_pulse%0d: got %b want 000", t, req_ack_o); end
    end
    req_sel_i = '0;
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc;
    logic [3:0] masks [3];
    masks[0] = 4'hF; masks[1] = 4'h3; masks[2] = 4'hF;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_req(1, 1'b1, masks[t], 24'h000100 + 24'(t), 16'hA000 + 16'(t));
      wait_sel(ok, cyc);
      if (t > 0) begin
        total++;
        if (!ok || cyc + 1 != 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 3", t, cyc + 1); end
      end
      total++;
      if (bus_cmd() !== exp_cmd(1) || grant_o !== 2'd1) begin
        bad++; $display("FAIL b2b_cmd%0d: got mask=%h g=%0d want %h 1", t, vif.vram_mask_o, grant_o, masks[t]);
      end
      serve(1, 16'h0000);
      total++;
      if (req_ack_o !== 3'b010) begin bad++; $display("FAIL b2b_ack%0d: got %b want 010", t, req_ack_o); end
    end
    req_sel_i = '0;
    model_ptr = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    vif.vram_ack_i = 1'b1;
    vif.vram_data_i = 16'hFFFF;
    @(negedge clk);
    vif.vram_ack_i = 1'b0;
    total++;
    if ({req_ack_o, busy_o, vif.vram_sel_o} !== 5'b0) begin
      bad++; $display("FAIL stray_ack: got ack=%b busy=%b sel=%b want 000 0 0", req_ack_o, busy_o, vif.vram_sel_o);
    end
    @(negedge clk);
    total++;
    if (req_ack_o !== 3'b000) begin bad++; $display("FAIL stray_ack_late: got %b want 000", req_ack_o); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    do_reset();
    set_req(0, 1'b0, 4'h0, 24'h000200, 16'h0);
    wait_sel(ok, cyc);
    serve(0, 16'h1234);
    req_sel_i[0] = 1'b0;
    model_ptr = 1;
    @(negedge clk);
    set_req(1, 1'b1, 4'h5, 24'h000300, 16'h5555);
    wait_sel(ok, cyc);
    total++;
    if (!ok || grant_o !== 2'd1) begin bad++; $display("FAIL midrst_pre: got ok=%0d g=%0d want 1 1", ok, grant_o); end
    #2 reset_n_i = 1'b0;
    #1;
    total++;
    if ({vif.vram_sel_o, req_ack_o, busy_o} !== 5'b0) begin
      bad++; $display("FAIL midrst_async: got sel=%b ack=%b busy=%b want 0 000 0", vif.vram_sel_o, req_ack_o, busy_o);
    end
    @(negedge clk);
    reset_n_i = 1'b1;
    model_ptr = 0;
    set_req(0, 1'b1, 4'h1, 24'h000400, 16'h4444);
    wait_sel(ok, cyc);
    total++;
    if (!ok || int'(grant_o) != rr_pick(req_sel_i, model_ptr)) begin
      bad++; $display("FAIL midrst_ptr: got g=%0d want %0d", grant_o, rr_pick(req_sel_i, model_ptr));
    end
    serve(1, 16'h0);
    total++;
    if (req_ack_o !== 3'b001) begin bad++; $display("FAIL midrst_ack: got %b want 001", req_ack_o); end
    req_sel_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit ok; int cyc, e;
    logic [DW-1:0] rd;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < N; r++)
        if (!req_sel_i[r] && $urandom_range(0, 1) == 1)
          set_req(r, 1'($urandom), 4'($urandom), 24'($urandom), 16'($urandom));
      if (req_sel_i == '0) set_req(int'($urandom_range(0, N - 1)), 1'b1, 4'hC, 24'($urandom), 16'($urandom));
      e = rr_pick(req_sel_i, model_ptr);
      wait_sel(ok, cyc);
      total++;
      if (!ok || int'(grant_o) != e || bus_cmd() !== exp_cmd(e)) begin
        bad++; $display("FAIL rand_grant%0d: got g=%0d cmd=%h want %0d %h", t, grant_o, bus_cmd(), e, exp_cmd(e));
      end
      req_addr_i[e*AW +: AW] = ~c_addr[e];
      if ($urandom_range(0, 3) == 0) req_sel_i[e] = 1'b0;
      rd = 16'($urandom);
      serve(int'($urandom_range(0, 4)), rd);
      total++;
      if ({req_ack_o, req_data_o, vif.vram_sel_o} !== {oh(e), rd, 1'b0} || bus_cmd() !== exp_cmd(e)) begin
        bad++; $display("FAIL rand_ack%0d: got ack=%b data=%h sel=%b want %b %h 0", t, req_ack_o, req_data_o, vif.vram_sel_o, oh(e), rd);
      end
      req_sel_i[e] = 1'b0;
      model_ptr = (e + 1) % N;
      @(negedge clk);
      total++;
      if (req_ack_o !== 3'b000) begin bad++; $display("FAIL rand_pulse%0d: got %b want 000", t, req_ack_o); end
    end
    req_sel_i = '0;
  endtask

`ifdef VRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int cyc, n;
    do_reset();
    set_req(0, 1'b0, 4'h0, 24'h000500, 16'h0);
    wait_sel(ok, cyc);
    serve(0, 16'hBEEF);
    req_sel_i[0] = 1'b0;
    @(negedge clk);
    set_req(1, 1'b0, 4'h0, 24'h000600, 16'h0);
    wait_sel(ok, cyc);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vif.vram_sel_o) n++;
      else break;
    end
    total++;
    if (n != TO) begin bad++; $display("FAIL to_cycles: got %0d want %0d", n, TO); end
    total++;
    if ({req_ack_o, req_data_o, timeout_o} !== {3'b010, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL to_ack: got ack=%b data=%h to=%b want 010 0000 1", req_ack_o, req_data_o, timeout_o);
    end
    req_sel_i = '0;
    repeat (5) @(negedge clk);
    total++;
    if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
    do_reset();
    @(negedge clk);
    total++;
    if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid();
    test_random();
`ifdef VRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
